// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus-cycle engine: state encoding, RTC register map, idle bus levels.
// Pure declarations; no timing of its own.
package rtc_bus_pkg;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_A_SETUP = 4'd1;
  localparam logic [3:0] S_A_PULSE = 4'd2;
  localparam logic [3:0] S_A_HOLD  = 4'd3;
  localparam logic [3:0] S_GAP     = 4'd4;
  localparam logic [3:0] S_D_SETUP = 4'd5;
  localparam logic [3:0] S_D_PULSE = 4'd6;
  localparam logic [3:0] S_D_HOLD  = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  typedef enum logic [3:0] {
    IDLE    = S_IDLE,
    A_SETUP = S_A_SETUP,
    A_PULSE = S_A_PULSE,
    A_HOLD  = S_A_HOLD,
    GAP     = S_GAP,
    D_SETUP = S_D_SETUP,
    D_PULSE = S_D_PULSE,
    D_HOLD  = S_D_HOLD,
    DONE    = S_DONE
  } state_t;

  // RTC register addresses used by the control FSM
  localparam logic [7:0] RTC_SEC   = 8'h21;
  localparam logic [7:0] RTC_MIN   = 8'h22;
  localparam logic [7:0] RTC_HOUR  = 8'h23;
  localparam logic [7:0] RTC_DAY   = 8'h24;
  localparam logic [7:0] RTC_MONTH = 8'h25;
  localparam logic [7:0] RTC_YEAR  = 8'h26;
  localparam logic [7:0] RTC_TIMER = 8'h33;
  localparam logic [7:0] RTC_CMD   = 8'hF0;

  localparam logic AD_IDLE = 1'b1;
  localparam logic CS_IDLE = 1'b1;
  localparam logic RD_IDLE = 1'b1;
  localparam logic WR_IDLE = 1'b1;

  // A zero duration is treated as one cycle.
  function automatic int t_eff(input int t);
    return (t < 1) ? 1 : t;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter with a zero flag, timing every bus-cycle phase.
// Load takes effect on the next edge; counts down to 0 and holds there.
module rtc_phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rtc_bus_cycle.sv
// RTC multiplexed-AD bus-cycle engine: address phase, gap, read/write data phase, one-cycle done.
// 2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP+1 cycles per access; optional RTC_BUS_STATS_EN adds rd/wr counters.
module rtc_bus_cycle
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 3,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
`ifdef RTC_BUS_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  if (T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 1 || T_GAP < 1) begin : g_zero_timing
    $warning("rtc_bus_cycle: T_* of 0 is illegal and is treated as 1");
  end
  if (T_SETUP > 2**CW || T_PULSE > 2**CW || T_HOLD > 2**CW || T_GAP > 2**CW) begin : g_cw_small
    $error("rtc_bus_cycle: a T_* value exceeds 2**CW");
  end

  localparam logic [CW-1:0] LD_SETUP = CW'(t_eff(T_SETUP) - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(t_eff(T_PULSE) - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(t_eff(T_HOLD) - 1);
  localparam logic [CW-1:0] LD_GAP   = CW'(t_eff(T_GAP) - 1);

  state_t        state, state_nxt;
  logic          load, zero;
  logic [CW-1:0] load_val;
  logic          req_rw, rw_nxt;
  logic [7:0]    req_addr, addr_nxt, req_wdata, wdata_nxt;
  logic [7:0]    ad_out_nxt;
  logic          ad_oe_nxt, a_d_nxt, cs_nxt, rd_nxt, wr_nxt, busy_nxt, done_nxt;

  rtc_phase_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Outputs are decoded from the next state so they register on the same edge as the state.
  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    load_val   = '0;
    rw_nxt     = req_rw;
    addr_nxt   = req_addr;
    wdata_nxt  = req_wdata;
    unique case (state)
      IDLE: if (start) begin
        state_nxt = A_SETUP; load = 1'b1; load_val = LD_SETUP;
        rw_nxt = rw; addr_nxt = addr; wdata_nxt = wdata;
      end
      A_SETUP: if (zero) begin state_nxt = A_PULSE; load = 1'b1; load_val = LD_PULSE; end
      A_PULSE: if (zero) begin state_nxt = A_HOLD;  load = 1'b1; load_val = LD_HOLD;  end
      A_HOLD:  if (zero) begin state_nxt = GAP;     load = 1'b1; load_val = LD_GAP;   end
      GAP:     if (zero) begin state_nxt = D_SETUP; load = 1'b1; load_val = LD_SETUP; end
      D_SETUP: if (zero) begin state_nxt = D_PULSE; load = 1'b1; load_val = LD_PULSE; end
      D_PULSE: if (zero) begin state_nxt = D_HOLD;  load = 1'b1; load_val = LD_HOLD;  end
      D_HOLD:  if (zero) begin state_nxt = DONE;    load = 1'b1; end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    ad_out_nxt = '0;
    ad_oe_nxt  = 1'b0;
    a_d_nxt    = AD_IDLE;
    cs_nxt     = CS_IDLE;
    rd_nxt     = RD_IDLE;
    wr_nxt     = WR_IDLE;
    busy_nxt   = (state_nxt != IDLE);
    done_nxt   = 1'b0;
    unique case (state_nxt)
      A_SETUP, A_PULSE, A_HOLD: begin
        a_d_nxt    = ~AD_IDLE;
        cs_nxt     = ~CS_IDLE;
        ad_oe_nxt  = 1'b1;
        ad_out_nxt = addr_nxt;
        if (state_nxt == A_PULSE) wr_nxt = ~WR_IDLE;
      end
      D_SETUP, D_PULSE, D_HOLD: begin
        cs_nxt = ~CS_IDLE;
        if (rw_nxt) begin
          if (state_nxt == D_PULSE) rd_nxt = ~RD_IDLE;
        end else begin
          ad_oe_nxt  = 1'b1;
          ad_out_nxt = wdata_nxt;
          if (state_nxt == D_PULSE) wr_nxt = ~WR_IDLE;
        end
      end
      DONE:    done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_rw    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      ad_out    <= '0;
      ad_oe     <= 1'b0;
      a_d       <= AD_IDLE;
      cs        <= CS_IDLE;
      rd        <= RD_IDLE;
      wr        <= WR_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
    end else begin
      req_rw    <= rw_nxt;
      req_addr  <= addr_nxt;
      req_wdata <= wdata_nxt;
      ad_out    <= ad_out_nxt;
      ad_oe     <= ad_oe_nxt;
      a_d       <= a_d_nxt;
      cs        <= cs_nxt;
      rd        <= rd_nxt;
      wr        <= wr_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      // RTC data is sampled on the last cycle of the read strobe
      if (state == D_PULSE && zero && req_rw) rdata <= ad_in;
    end
  end

`ifdef RTC_BUS_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == DONE) begin
      if (req_rw) begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end else begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Bench for rtc_bus_cycle: table vectors, random accesses and corner sequences against a phase-arithmetic model.
module tb_rtc_bus_cycle;
  import rtc_bus_pkg::*;

  localparam int TS = 2, TP = 4, TH = 2, TG = 3;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, rw = 1'b0;
  logic [7:0] addr = '0, wdata = '0, ad_in = '0;
  logic [7:0] ad_out, rdata;
  logic       ad_oe, a_d, cs, rd, wr, busy, done;
`ifdef RTC_BUS_STATS_EN
  logic [15:0] rd_count, wr_count;
  int exp_rd = 0, exp_wr = 0;
`endif

  int tests = 0, fails = 0, cyc = 0;
  logic [7:0] exp_rdata = 8'h00;

  typedef struct packed {
    logic       ad_oe;
    logic [7:0] ad_out;
    logic       a_d, cs, rd, wr, busy, done;
    logic [7:0] rdata;
  } obs_t;

  typedef struct {
    logic       rw;
    logic [7:0] addr, wdata, rdv, exp_rdata;
  } vec_t;

  rtc_bus_cycle #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG), .CW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
    .rdata(rdata), .busy(busy), .done(done)
`ifdef RTC_BUS_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1);
  end

  // Expected bus state t cycles after the accepting edge, from the phase durations alone.
  function automatic obs_t model(input int t, input logic m_rw, input logic [7:0] m_addr,
                                 input logic [7:0] m_wdata, input logic [7:0] m_rdv,
                                 input logic [7:0] prev_rdata);
    obs_t o;
    int a_p, a_h, gap, d_s, d_p, d_h, dn;
    a_p = TS; a_h = a_p + TP; gap = a_h + TH; d_s = gap + TG;
    d_p = d_s + TS; d_h = d_p + TP; dn = d_h + TH;
    o.ad_oe = 1'b0; o.ad_out = 8'h00; o.a_d = 1'b1; o.cs = 1'b1; o.rd = 1'b1; o.wr = 1'b1;
    o.busy = (t <= dn); o.done = 1'b0; o.rdata = prev_rdata;
    if (t < gap) begin
      o.a_d = 1'b0; o.cs = 1'b0; o.ad_oe = 1'b1; o.ad_out = m_addr;
      o.wr = !(t >= a_p && t < a_h);
    end else if (t >= d_s && t < dn) begin
      o.cs = 1'b0;
      if (m_rw) o.rd = !(t >= d_p && t < d_h);
      else begin
        o.ad_oe = 1'b1; o.ad_out = m_wdata; o.wr = !(t >= d_p && t < d_h);
      end
    end else if (t == dn) begin
      o.done = 1'b1;
    end
    if (m_rw && t >= d_h) o.rdata = m_rdv;
    return o;
  endfunction

  task automatic check_cycle(input string name, input int t, input obs_t exp);
    obs_t act;
    act.ad_oe = ad_oe; act.ad_out = ad_oe ? ad_out : 8'h00; act.a_d = a_d; act.cs = cs;
    act.rd = rd; act.wr = wr; act.busy = busy; act.done = done; act.rdata = rdata;
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
    end
    tests++;
    assert (!(ad_oe === 1'b1 && rd === 1'b0)) else begin
      fails++;
      $display("FAIL oe_while_rd t=%0d actual ad_oe=%b rd=%b required no overlap", t, ad_oe, rd);
    end
  endtask

  task automatic run_txn(input string name, input logic t_rw, input logic [7:0] t_addr,
                         input logic [7:0] t_wdata, input logic [7:0] t_rdv, input int stray,
                         input bit chained, input int stop_at, output int done_cyc);
    int ndone = 0;
    done_cyc = -1;
    if (!chained) @(negedge clk);
    start = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wdata;
    @(posedge clk);
    for (int t = 0; t <= stop_at; t++) begin
      @(negedge clk);
      check_cycle(name, t, model(t, t_rw, t_addr, t_wdata, t_rdv, exp_rdata));
      if (done === 1'b1) begin ndone++; done_cyc = cyc; end
      ad_in = (rd === 1'b0) ? t_rdv : 8'($urandom);
      start = (t + 1 == stray);
      rw = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
    end
    start = 1'b0;
    if (stop_at >= 20) begin
      if (t_rw) exp_rdata = t_rdv;
`ifdef RTC_BUS_STATS_EN
      if (t_rw) exp_rd++; else exp_wr++;
`endif
      tests++;
      if (ndone != 1) begin
        fails++;
        $display("FAIL %s_done_count actual=%0d required=1", name, ndone);
      end
    end
  endtask

  initial begin
    vec_t vecs[6];
    int dc1, dc2, dc;
    vecs[0] = '{1'b0, RTC_SEC,  8'h45, 8'h00, 8'h00};
    vecs[1] = '{1'b1, RTC_MIN,  8'h00, 8'h37, 8'h37};
    vecs[2] = '{1'b0, 8'h30,    8'hAA, 8'h11, 8'h37};
    vecs[3] = '{1'b1, 8'h0F,    8'h00, 8'hC3, 8'hC3};
    vecs[4] = '{1'b1, 8'h00,    8'h5A, 8'hFF, 8'hFF};
    vecs[5] = '{1'b0, RTC_CMD,  8'h00, 8'h22, 8'hFF};

    @(negedge clk); @(negedge clk);
    check_cycle("reset_state", 0, model(1000, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00));
    tests++;
    if (ad_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_ad_out actual=%h required=00", ad_out);
    end
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_txn("vec", vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].rdv, -1, 1'b0, 20, dc);
      tests++;
      if (rdata !== vecs[i].exp_rdata) begin
        fails++;
        $display("FAIL vec%0d_rdata actual=%h required=%h", i, rdata, vecs[i].exp_rdata);
      end
    end

    run_txn("stray_busy", 1'b0, 8'h21, 8'h45, 8'h00, 5, 1'b0, 20, dc);
    run_txn("stray_done", 1'b1, 8'h22, 8'h00, 8'h6B, 20, 1'b0, 20, dc);
    @(negedge clk);
    check_cycle("stray_done_idle", 21, model(1000, 1'b0, 8'h00, 8'h00, 8'h00, exp_rdata));

    run_txn("b2b_first", 1'b0, 8'h24, 8'h12, 8'h00, -1, 1'b0, 20, dc1);
    run_txn("b2b_second", 1'b0, 8'h25, 8'h34, 8'h00, -1, 1'b1, 20, dc2);
    tests++;
    if (dc2 - dc1 != 21) begin
      fails++;
      $display("FAIL b2b_spacing actual=%0d required=21", dc2 - dc1);
    end

    for (int i = 0; i < 30; i++) begin
      run_txn("rand", 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), -1, 1'b0, 20, dc);
    end

    run_txn("pre_reset_read", 1'b1, RTC_HOUR, 8'h00, 8'hA5, -1, 1'b0, 20, dc);
`ifdef RTC_BUS_STATS_EN
    tests++;
    if (rd_count !== 16'(exp_rd) || wr_count !== 16'(exp_wr)) begin
      fails++;
      $display("FAIL stats actual=%0d/%0d required=%0d/%0d", rd_count, wr_count, exp_rd, exp_wr);
    end
`endif

    run_txn("mid_reset", 1'b1, RTC_DAY, 8'h00, 8'h5C, -1, 1'b0, 13, dc);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    exp_rdata = 8'h00;
    check_cycle("mid_reset_async", 14, model(1000, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00));
    @(negedge clk);
    reset = 1'b0;
`ifdef RTC_BUS_STATS_EN
    exp_rd = 0; exp_wr = 0;
    tests++;
    if (rd_count !== 16'h0 || wr_count !== 16'h0) begin
      fails++;
      $display("FAIL stats_reset actual=%0d/%0d required=0/0", rd_count, wr_count);
    end
`endif
    run_txn("post_reset", 1'b0, RTC_YEAR, 8'h99, 8'h00, -1, 1'b0, 20, dc);
    run_txn("post_reset_rd", 1'b1, RTC_TIMER, 8'h00, 8'h3C, -1, 1'b0, 20, dc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
